// File: rtl/f_pc_unit.sv
// f_pc_unit -- fetch-stage program counter.
//
// Holds the fetch PC, selects the next PC each cycle and produces the
// fetch-stage values that are captured by the F/D pipeline register.
//
// Next-PC priority (highest first):
//   reset -> RESET_PC
//   Req -> HANDLER_PC
//   eretD and not stallF -> EPC
//   stallF -> hold
//   redirectD -> targetD
//   otherwise -> PCF + 4
//
// Ports:
//   clk        in   1   clock, rising edge
//   reset      in   1   synchronous active-high reset
//   stallF     in   1   hold PC (hazard stall)
//   Req        in   1   exception/interrupt request from CP0
//   eretD      in   1   ERET decoded in D
//   EPC        in  32   return address from CP0
//   redirectD  in   1   branch taken / jump resolved in D
//   targetD    in  32   redirect target
//   isBJD      in   1   instruction in D is a branch/jump
//   InsIM      in  32   instruction word read from IM at PCF
//   PCF        out 32   current fetch PC (IM address)
//   InsF       out 32   fetched instruction (zeroed on exception or ERET)
//   PC8F       out 32   PCF + 8
//   ExcF       out  5   fetch exception code (4 = AdEL, 0 = none)
//   BDInF      out  1   fetched instruction sits in a delay slot
//
// Build option:
//   F_PC_RANGE_CHECK_EN  when defined, fetches outside 32'h3000..32'h6FFC
//                        also raise AdEL; otherwise only misalignment does.

module f_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        Req,
  input  logic        eretD,
  input  logic [31:0] EPC,
  input  logic        redirectD,
  input  logic [31:0] targetD,
  input  logic        isBJD,
  input  logic [31:0] InsIM,
  output logic [31:0] PCF,
  output logic [31:0] InsF,
  output logic [31:0] PC8F,
  output logic [4:0]  ExcF,
  output logic        BDInF
);

  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [31:0] PC_LO    = 32'h0000_3000;
  localparam logic [31:0] PC_HI    = 32'h0000_6FFC;

  // Declaration initialiser gives a defined PC before the first reset edge.
  logic [31:0] pc_q = RESET_PC;
  logic        adel;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (Req) begin
      pc_q <= HANDLER_PC;
    end else if (eretD && !stallF) begin
      pc_q <= EPC;
    end else if (stallF) begin
      // An ERET arriving during a stall is retried once the stall clears.
      pc_q <= pc_q;
    end else if (redirectD) begin
      pc_q <= targetD;
    end else begin
      // Misaligned PCs still advance by 4; the exception is carried by ExcF.
      pc_q <= pc_q + 32'd4;
    end
  end

  always_comb begin
    adel = (pc_q[1:0] != 2'b00);
`ifdef F_PC_RANGE_CHECK_EN
    if ((pc_q < PC_LO) || (pc_q > PC_HI)) begin
      adel = 1'b1;
    end
`endif
  end

  assign PCF   = pc_q;
  assign PC8F  = pc_q + 32'd8;
  assign ExcF  = adel ? EXC_ADEL : EXC_NONE;
  // A faulting fetch or the slot behind an ERET is squashed to a NOP.
  assign InsF  = (adel || eretD) ? 32'd0 : InsIM;
  assign BDInF = isBJD;

`ifndef F_PC_RANGE_CHECK_EN
  // Bounds are only consulted when the range check is built in.
  logic unused_bounds;
  assign unused_bounds = ^{PC_LO, PC_HI};
`endif

endmodule

// File: tb/tb_f_pc_unit.sv
module tb_f_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallF;
  logic        Req;
  logic        eretD;
  logic [31:0] EPC;
  logic        redirectD;
  logic [31:0] targetD;
  logic        isBJD;
  logic [31:0] InsIM;
  logic [31:0] PCF;
  logic [31:0] InsF;
  logic [31:0] PC8F;
  logic [4:0]  ExcF;
  logic        BDInF;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef F_PC_RANGE_CHECK_EN
  localparam logic [31:0] EXC_OOR = 32'd4;
`else
  localparam logic [31:0] EXC_OOR = 32'd0;
`endif

  f_pc_unit dut (
    .clk       (clk),
    .reset     (reset),
    .stallF    (stallF),
    .Req       (Req),
    .eretD     (eretD),
    .EPC       (EPC),
    .redirectD (redirectD),
    .targetD   (targetD),
    .isBJD     (isBJD),
    .InsIM     (InsIM),
    .PCF       (PCF),
    .InsF      (InsF),
    .PC8F      (PC8F),
    .ExcF      (ExcF),
    .BDInF     (BDInF)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then leave time for inputs to be changed and
  // outputs to settle before checking.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 1'b0; stallF = 1'b0; Req = 1'b0; eretD = 1'b0;
    EPC = 32'd0; redirectD = 1'b0; targetD = 32'd0; isBJD = 1'b0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    InsIM = 32'hDEAD_BEEF;
    #1;
    chk("pc_time_zero", PCF, 32'h3000);

    tick();
    reset = 1'b0;
    #1;
    chk("rst_pcf", PCF, 32'h3000);
    chk("rst_pc8f", PC8F, 32'h3008);
    chk("rst_excf", {27'd0, ExcF}, 32'd0);
    chk("rst_insf", InsF, 32'hDEAD_BEEF);
    chk("rst_bdinf", {31'd0, BDInF}, 32'd0);

    // Free-running sequential fetch
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("seq_pcf", PCF, 32'h3000 + 32'd4 * i);
      chk("seq_pc8f", PC8F, 32'h3008 + 32'd4 * i);
    end

    // Stall with a pending redirect: held for two cycles, then redirect applies
    stallF = 1'b1; redirectD = 1'b1; targetD = 32'h3100;
    tick();
    chk("stall_hold1", PCF, 32'h300C);
    tick();
    chk("stall_hold2", PCF, 32'h300C);
    stallF = 1'b0;
    tick();
    chk("stall_release", PCF, 32'h3100);
    redirectD = 1'b0;

    // Req beats stall and ERET in the same cycle
    Req = 1'b1; stallF = 1'b1; eretD = 1'b1; EPC = 32'h3040;
    #1;
    chk("req_insf_eret", InsF, 32'd0);
    tick();
    chk("req_pcf", PCF, 32'h4180);
    clear_inputs();

    // ERET without stall
    eretD = 1'b1; EPC = 32'h3040;
    #1;
    chk("eret_insf", InsF, 32'd0);
    tick();
    chk("eret_pcf", PCF, 32'h3040);
    // ERET while stalled: PC held, fetch squashed
    stallF = 1'b1; EPC = 32'h3200;
    tick();
    chk("eret_stall_pcf", PCF, 32'h3040);
    chk("eret_stall_insf", InsF, 32'd0);
    // stall drops: ERET retried
    stallF = 1'b0;
    tick();
    chk("eret_retry_pcf", PCF, 32'h3200);
    clear_inputs();
    #1;
    chk("plain_insf", InsF, 32'hDEAD_BEEF);

    // Misaligned redirect target
    redirectD = 1'b1; targetD = 32'h3002;
    tick();
    redirectD = 1'b0;
    #1;
    chk("misal_pcf", PCF, 32'h3002);
    chk("misal_excf", {27'd0, ExcF}, 32'd4);
    chk("misal_insf", InsF, 32'd0);
    tick();
    chk("misal_next_pcf", PCF, 32'h3006);
    chk("misal_next_excf", {27'd0, ExcF}, 32'd4);

    // Range boundaries
    redirectD = 1'b1; targetD = 32'h7000;
    tick();
    chk("r7000_pcf", PCF, 32'h7000);
    chk("r7000_excf", {27'd0, ExcF}, EXC_OOR);
    chk("r7000_insf", InsF, (EXC_OOR != 0) ? 32'd0 : 32'hDEAD_BEEF);
    targetD = 32'h6FFC;
    tick();
    chk("r6ffc_excf", {27'd0, ExcF}, 32'd0);
    targetD = 32'h2FFC;
    tick();
    chk("r2ffc_excf", {27'd0, ExcF}, EXC_OOR);
    targetD = 32'h3000;
    tick();
    chk("r3000_excf", {27'd0, ExcF}, 32'd0);
    targetD = 32'hFFFF_FFFC;
    tick();
    chk("wrap_pc8f", PC8F, 32'h0000_0004);
    redirectD = 1'b0;
    tick();
    chk("wrap_pcf", PCF, 32'h0000_0000);

    // Delay-slot flag, combinational and during stall
    isBJD = 1'b1;
    #1;
    chk("bd_flag", {31'd0, BDInF}, 32'd1);
    stallF = 1'b1;
    tick();
    chk("bd_flag_stall", {31'd0, BDInF}, 32'd1);
    isBJD = 1'b0;
    #1;
    chk("bd_flag_clr", {31'd0, BDInF}, 32'd0);

    // Reset during a redirect (and stall/Req/ERET) wins
    redirectD = 1'b1; targetD = 32'h3100; Req = 1'b1; eretD = 1'b1; EPC = 32'h3040;
    reset = 1'b1;
    tick();
    clear_inputs();
    #1;
    chk("rst_redirect_pcf", PCF, 32'h3000);
    tick();
    chk("rst_after_pcf", PCF, 32'h3004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/f_pc_unit.md
F_PC_UNIT -- requirements
Module: f_pc_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_3000, PC loaded on reset.
REQ-002 SHALL provide parameter HANDLER_PC, default 32'h0000_4180, PC loaded on exception request.
REQ-003 SHALL provide port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL provide port stallF, input, 1, hold PC (hazard stall, same cycle as stallD).
REQ-006 SHALL provide port Req, input, 1, exception/interrupt request from CP0.
REQ-007 SHALL provide port eretD, input, 1, ERET decoded in D stage.
REQ-008 SHALL provide port EPC, input, 32, return address from CP0.
REQ-009 SHALL provide port redirectD, input, 1, branch taken or jump resolved in D.
REQ-010 SHALL provide port targetD, input, 32, redirect target.
REQ-011 SHALL provide port isBJD, input, 1, instruction in D is a branch/jump.
REQ-012 SHALL provide port InsIM, input, 32, instruction word read combinationally from IM at PCF.
REQ-013 SHALL provide port PCF, output, 32, current fetch PC (also IM address).
REQ-014 SHALL provide ports InsF (32), PC8F (32), ExcF (5), BDInF (1), outputs feeding the F/D register.

Function
REQ-015 SHALL hold PC in one 32-bit register; PCF SHALL equal that register.
REQ-016 SHALL drive PC8F = PCF + 8, 32-bit wrap-around arithmetic.
REQ-017 SHALL select next PC per cycle with strict priority: reset -> RESET_PC; Req -> HANDLER_PC; eretD and not stallF -> EPC; stallF -> hold; redirectD -> targetD; else PCF + 4.
REQ-018 SHALL let Req override stallF and eretD in the same cycle.
REQ-019 SHALL ignore eretD while stallF is high (PC held, ERET retried next cycle).
REQ-020 SHALL flag ExcF = 5'd4 (AdEL) when PCF[1:0] != 0; otherwise ExcF = 5'd0 (range rule per REQ-030).
REQ-021 SHALL drive InsF = 32'd0 when ExcF != 0 or eretD is high; else InsF = InsIM.
REQ-022 SHALL drive BDInF = isBJD, including while stalled.
REQ-023 SHALL compute all outputs combinationally from the PC register and inputs; zero-latency to the F/D register.
REQ-024 SHALL not add PC+4 to a misaligned PC any differently; PC arithmetic SHALL ignore ExcF.

Reset
REQ-025 SHALL load PC = RESET_PC on the clock edge where reset is high, regardless of every other input.
REQ-026 SHALL, in the cycle after reset, present PCF = 32'h3000, PC8F = 32'h3008, ExcF = 0, BDInF = isBJD, InsF = InsIM.
REQ-027 SHALL initialise the PC register to RESET_PC at simulation time zero.
REQ-028 SHALL, on reset mid-stall or mid-redirect, discard the pending stall/redirect/ERET.

Configuration
REQ-029 SHALL support macro F_PC_RANGE_CHECK_EN.
REQ-030 SHALL, with F_PC_RANGE_CHECK_EN defined, also flag ExcF = 5'd4 when PCF < 32'h3000 or PCF > 32'h6FFC (inclusive bounds valid).
REQ-031 SHALL, without F_PC_RANGE_CHECK_EN, flag AdEL on misalignment only; 32'h7000 aligned fetches SHALL give ExcF = 0.

Verification
REQ-032 SHALL cover: reset, then 3 free cycles -> PCF 3000, 3004, 3008, 300C; PC8F = PCF+8.
REQ-033 SHALL cover: stallF high 2 cycles with redirectD=1, targetD=3100 -> PCF held; after release redirect applies, next PCF=3100.
REQ-034 SHALL cover: Req with stallF=1 and eretD=1 simultaneously -> next PCF=4180.
REQ-035 SHALL cover: eretD=1, EPC=3040 -> InsF=0 that cycle, next PCF=3040; repeat with stallF=1 -> PCF held, InsF=0.
REQ-036 SHALL cover: redirectD targetD=3002 -> next cycle ExcF=4, InsF=0; then targetD=7000 -> ExcF=4 with F_PC_RANGE_CHECK_EN, 0 without.
REQ-037 SHALL cover: isBJD=1 -> BDInF=1 same cycle; reset asserted during redirect -> next PCF=3000.
